baccarat_fsm: RTL



---
 rtl/baccarat_pkg.sv | 42 ++++
 rtl/baccarat_fsm_banker_draw.sv | 31 +++
 rtl/baccarat_fsm.sv | 128 ++++++++++++
 3 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat controller and its datapath.
// card_value is also meant for the scorehand blocks so both agree on face cards.
package baccarat_pkg;

    typedef enum logic [3:0] {
        RST,
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        CHECK_NAT,
        DEAL_P3,
        BANKER_CHK,
        DEAL_D3,
        RESULT,
        DONE
    } state_t;

    localparam logic [3:0] CARD_EMPTY = 4'd0;
    localparam logic [3:0] FACE_MIN   = 4'd10;

    // One bit per card register, in deal order.
    typedef struct packed {
        logic p1;
        logic d1;
        logic p2;
        logic d2;
        logic p3;
        logic d3;
    } load_t;

    localparam load_t LOAD_NONE = '0;

    // Baccarat point value of a raw card code: tens and faces count zero.
    function automatic logic [3:0] card_value(input logic [3:0] card);
        if (card == CARD_EMPTY || card >= FACE_MIN) begin
            return 4'd0;
        end
        return card;
    endfunction

endpackage

// File: rtl/baccarat_fsm_banker_draw.sv
// Banker third-card table: decides whether the dealer draws, given its
// two-card total and the point value of the player's third card.
module banker_draw (
    input  logic [3:0] dscore,
    input  logic [3:0] v,
    output logic       draw
);

    logic v_2_to_7;
    logic v_4_to_7;
    logic v_6_to_7;

    assign v_2_to_7 = (v >= 4'd2) && (v <= 4'd7);
    assign v_4_to_7 = (v >= 4'd4) && (v <= 4'd7);
    assign v_6_to_7 = (v >= 4'd6) && (v <= 4'd7);

    always_comb begin
        // NOTE: every path assigns draw; the default first keeps this purely
        // combinational instead of inferring a latch.
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = v_2_to_7;
            4'd5:             draw = v_4_to_7;
            4'd6:             draw = v_6_to_7;
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_fsm.sv
// Baccarat sequencing controller: deals cards via one-cycle load strobes,
// applies the third-card rules and latches the result onto the win lights.
module baccarat_fsm
    import baccarat_pkg::*;
#(
    parameter logic [3:0] NATURAL_MIN     = 4'd8,
    parameter logic [3:0] PLAYER_DRAW_MAX = 4'd5
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    state_t     state;
    state_t     state_next;
    load_t      loads;
    logic [3:0] pcard3_value;
    logic       banker_draws;
    logic       is_natural;
    logic       player_draws;
    logic       player_ahead;
    logic       dealer_ahead;

    assign pcard3_value = card_value(pcard3);
    assign is_natural   = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);
    assign player_draws = (pscore <= PLAYER_DRAW_MAX);
    assign player_ahead = (pscore > dscore);
    assign dealer_ahead = (dscore > pscore);

    banker_draw u_banker_draw (
        .dscore (dscore),
        .v      (pcard3_value),
        .draw   (banker_draws)
    );

    always_ff @(posedge slow_clock) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state            <= RST;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else begin
            state <= state_next;
            // A tie falls out naturally: neither side is ahead, both lights set.
            if (state == RESULT) begin
                player_win_light <= !dealer_ahead;
                dealer_win_light <= !player_ahead;
            end
        end
    end

    always_comb begin
        state_next = state;
        loads      = LOAD_NONE;
        case (state)
            RST: begin
                state_next = DEAL_P1;
            end
            DEAL_P1: begin
                loads.p1   = 1'b1;
                state_next = DEAL_D1;
            end
            DEAL_D1: begin
                loads.d1   = 1'b1;
                state_next = DEAL_P2;
            end
            DEAL_P2: begin
                loads.p2   = 1'b1;
                state_next = DEAL_D2;
            end
            DEAL_D2: begin
                loads.d2   = 1'b1;
                state_next = CHECK_NAT;
            end
            CHECK_NAT: begin
                // Player standing on 6-7 leaves the banker on the simple rule.
                if (is_natural) begin
                    state_next = RESULT;
                end else if (player_draws) begin
                    state_next = DEAL_P3;
                end else if (dscore <= PLAYER_DRAW_MAX) begin
                    state_next = DEAL_D3;
                end else begin
                    state_next = RESULT;
                end
            end
            DEAL_P3: begin
                loads.p3   = 1'b1;
                state_next = BANKER_CHK;
            end
            BANKER_CHK: begin
                state_next = banker_draws ? DEAL_D3 : RESULT;
            end
            DEAL_D3: begin
                loads.d3   = 1'b1;
                state_next = RESULT;
            end
            RESULT: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = RST;
            end
        endcase
    end

    assign load_pcard1 = loads.p1;
    assign load_dcard1 = loads.d1;
    assign load_pcard2 = loads.p2;
    assign load_dcard2 = loads.d2;
    assign load_pcard3 = loads.p3;
    assign load_dcard3 = loads.d3;

endmodule
